// File: rtl/hazard_scoreboard_if.sv
// Hazard scoreboard bus: groups the issue request, the ID/EX operand
// addresses, the forwarding-stage status and the scoreboard results.
//   master : pipeline control side (drives issue/operand/forwarding info)
//   slave  : the scoreboard (returns forward_sel, stall, pending_mask,
//            stall_count, hazard_err)
interface hazard_scoreboard_if #(
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int REG_AW  = 5,
  parameter int MAX_LAT = 8
);
  localparam int LW       = $clog2(MAX_LAT + 1);
  localparam int SW       = $clog2(NUM_FWD + 1);
  localparam int NUM_REGS = 2 ** REG_AW;

  logic                      issue_valid;
  logic [REG_AW-1:0]         issue_rd;
  logic                      issue_we;
  logic [LW-1:0]             issue_lat;
  logic [NUM_SRC*REG_AW-1:0] id_rs;
  logic [NUM_SRC-1:0]        id_rs_used;
  logic [NUM_SRC*REG_AW-1:0] ex_rs;
  logic [NUM_FWD*REG_AW-1:0] fwd_rd;
  logic [NUM_FWD-1:0]        fwd_we;
  logic [NUM_FWD-1:0]        fwd_ready;
  logic                      flush;
  logic [NUM_SRC*SW-1:0]     forward_sel;
  logic                      stall;
  logic [NUM_REGS-1:0]       pending_mask;
  logic [31:0]               stall_count;
  logic                      hazard_err;

  modport master (
    output issue_valid, issue_rd, issue_we, issue_lat, id_rs, id_rs_used,
           ex_rs, fwd_rd, fwd_we, fwd_ready, flush,
    input  forward_sel, stall, pending_mask, stall_count, hazard_err
  );

  modport slave (
    input  issue_valid, issue_rd, issue_we, issue_lat, id_rs, id_rs_used,
           ex_rs, fwd_rd, fwd_we, fwd_ready, flush,
    output forward_sel, stall, pending_mask, stall_count, hazard_err
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: tracks per-register result latency, raises
// RAW/WAW stalls for the ID instruction, selects forwarding sources for the
// EX operands and flags forwarding from a stage whose data is not ready.
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : hazard_scoreboard_if.slave (issue, operands, forwarding, results)
module hazard_scoreboard #(
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int REG_AW  = 5,
  parameter int MAX_LAT = 8
) (
  input logic                clk,
  input logic                rst_n,
  hazard_scoreboard_if.slave bus
);
  localparam int LW       = $clog2(MAX_LAT + 1);
  localparam int SW       = $clog2(NUM_FWD + 1);
  localparam int NUM_REGS = 2 ** REG_AW;
  localparam logic [LW-1:0] LAT_CAP = LW'(MAX_LAT);

  logic [LW-1:0]         cnt [NUM_REGS];
  logic                  last_valid;
  logic [REG_AW-1:0]     last_rd;
  logic                  raw_hit;
  logic                  waw_hit;
  logic                  stall_i;
  logic                  create;
  logic [LW-1:0]         load_val;
  logic [NUM_SRC*SW-1:0] fsel;
  logic                  fwd_bad;
  logic [NUM_REGS-1:0]   pmask;
  logic [31:0]           scount;
  logic                  err;

  // A counter of 1 means the result reaches a forwarding path next cycle,
  // so only counts of 2 or more block a reader.
  always_comb begin
    raw_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (bus.id_rs_used[i] && (bus.id_rs[i*REG_AW +: REG_AW] != '0) &&
          (cnt[bus.id_rs[i*REG_AW +: REG_AW]] > LW'(1)))
        raw_hit = 1'b1;
    end
  end

  always_comb begin
    waw_hit  = bus.issue_we && (bus.issue_rd != '0) &&
               (cnt[bus.issue_rd] > bus.issue_lat);
    // Gating with rst_n keeps stall low during reset independent of state.
    stall_i  = rst_n && bus.issue_valid && (raw_hit || waw_hit);
    create   = bus.issue_valid && !stall_i && !bus.flush && bus.issue_we &&
               (bus.issue_rd != '0) && (bus.issue_lat != '0);
    load_val = (bus.issue_lat > LAT_CAP) ? LAT_CAP : bus.issue_lat;
  end

  // Lowest stage index wins: a slot is filled only while still empty.
  always_comb begin
    fsel    = '0;
    fwd_bad = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      for (int unsigned j = 0; j < NUM_FWD; j++) begin
        if ((fsel[i*SW +: SW] == '0) && bus.fwd_we[j] &&
            (bus.ex_rs[i*REG_AW +: REG_AW] != '0) &&
            (bus.fwd_rd[j*REG_AW +: REG_AW] == bus.ex_rs[i*REG_AW +: REG_AW])) begin
          fsel[i*SW +: SW] = SW'(j + 1);
          if (!bus.fwd_ready[j])
            fwd_bad = 1'b1;
        end
      end
    end
  end

  always_comb begin
    pmask = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++)
      pmask[r] = (cnt[r] != '0);
  end

  // Flush kill of the just-issued entry takes priority over the decrement;
  // a fresh load is not decremented in its load cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++)
        cnt[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (r == 0)
          cnt[r] <= '0;
        else if (bus.flush && last_valid && (last_rd == REG_AW'(r)))
          cnt[r] <= '0;
        else if (create && (bus.issue_rd == REG_AW'(r)))
          cnt[r] <= load_val;
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_valid <= 1'b0;
      last_rd    <= '0;
    end else begin
      last_valid <= create;
      if (create)
        last_rd <= bus.issue_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scount <= '0;
      err    <= 1'b0;
    end else begin
      if (stall_i && (scount != '1))
        scount <= scount + 32'd1;
      if (fwd_bad)
        err <= 1'b1;
    end
  end

  assign bus.forward_sel  = fsel;
  assign bus.stall        = stall_i;
  assign bus.pending_mask = pmask;
  assign bus.stall_count  = scount;
  assign bus.hazard_err   = err;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: a forwarding-select vector
// table, directed multi-cycle hazard sequences, then randomized traffic
// compared against a ready-time reference model.
module tb_hazard_scoreboard;
  localparam int NSRC = 2;
  localparam int NFWD = 2;
  localparam int AW   = 5;
  localparam int MLAT = 8;
  localparam int NREG = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  hazard_scoreboard_if #(.NUM_SRC(NSRC), .NUM_FWD(NFWD), .REG_AW(AW),
                         .MAX_LAT(MLAT)) bus ();

  hazard_scoreboard #(.NUM_SRC(NSRC), .NUM_FWD(NFWD), .REG_AW(AW),
                      .MAX_LAT(MLAT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // Reference model: each register holds the absolute cycle at which its
  // result is forwardable; remaining latency is that minus the current cycle.
  longint now;
  longint ready_at [NREG];
  bit     m_last_valid;
  int     m_last_rd;
  bit     m_err;
  longint m_scount;

  function automatic void reset_model();
    for (int r = 0; r < NREG; r++) ready_at[r] = 0;
    m_last_valid = 0;
    m_last_rd    = 0;
    m_err        = 0;
    m_scount     = 0;
  endfunction

  function automatic longint m_cnt(input int r);
    longint d;
    if (r == 0) return 0;
    d = ready_at[r] - now;
    return (d > 0) ? d : 0;
  endfunction

  function automatic bit m_stall();
    bit raw;
    bit waw;
    int rs;
    raw = 0;
    if (!rst_n || !bus.issue_valid) return 0;
    for (int i = 0; i < NSRC; i++) begin
      rs = int'(bus.id_rs[i*AW +: AW]);
      if (bus.id_rs_used[i] && rs != 0 && m_cnt(rs) >= 2) raw = 1;
    end
    waw = bus.issue_we && (bus.issue_rd != 0) &&
          (m_cnt(int'(bus.issue_rd)) > longint'(bus.issue_lat));
    return raw || waw;
  endfunction

  function automatic int m_fsel(input int i);
    int rs;
    rs = int'(bus.ex_rs[i*AW +: AW]);
    if (rs == 0) return 0;
    for (int j = 0; j < NFWD; j++)
      if (bus.fwd_we[j] && int'(bus.fwd_rd[j*AW +: AW]) == rs) return j + 1;
    return 0;
  endfunction

  function automatic logic [3:0] m_fsel_vec();
    logic [3:0] v;
    v = '0;
    for (int i = 0; i < NSRC; i++) v[i*2 +: 2] = 2'(m_fsel(i));
    return v;
  endfunction

  function automatic logic [31:0] m_pmask();
    logic [31:0] m;
    m = '0;
    for (int r = 0; r < NREG; r++) m[r] = (m_cnt(r) != 0);
    return m;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    bit     s, eff, bad, kill_v, ld, r_n;
    int     kill_r, ld_r, f;
    longint ld_v, lat;
    r_n    = rst_n;
    s      = m_stall();
    eff    = bus.issue_valid && !s && !bus.flush;
    kill_v = bus.flush && m_last_valid;
    kill_r = m_last_rd;
    lat    = longint'(bus.issue_lat);
    ld     = eff && bus.issue_we && (bus.issue_rd != 0) && (lat != 0);
    ld_r   = int'(bus.issue_rd);
    ld_v   = (lat > MLAT) ? MLAT : lat;
    bad    = 0;
    for (int i = 0; i < NSRC; i++) begin
      f = m_fsel(i);
      if (f != 0 && !bus.fwd_ready[f-1]) bad = 1;
    end
    @(posedge clk);
    now++;
    if (r_n) begin
      if (kill_v) ready_at[kill_r] = 0;
      if (ld) ready_at[ld_r] = now + ld_v;
      m_last_valid = ld;
      if (ld) m_last_rd = ld_r;
      if (s && m_scount < 64'hFFFF_FFFF) m_scount++;
      if (bad) m_err = 1;
    end
    #1;
  endtask

  task automatic idle();
    bus.issue_valid = 0;
    bus.issue_rd    = '0;
    bus.issue_we    = 0;
    bus.issue_lat   = '0;
    bus.id_rs       = '0;
    bus.id_rs_used  = '0;
    bus.ex_rs       = '0;
    bus.fwd_rd      = '0;
    bus.fwd_we      = '0;
    bus.fwd_ready   = '1;
    bus.flush       = 0;
  endtask

  task automatic do_issue(input int rd, input int lat);
    bus.issue_valid = 1;
    bus.issue_we    = 1;
    bus.issue_rd    = 5'(rd);
    bus.issue_lat   = 4'(lat);
  endtask

  task automatic read_src(input int rs);
    bus.issue_valid     = 1;
    bus.issue_we        = 0;
    bus.id_rs[4:0]      = 5'(rs);
    bus.id_rs_used      = 2'b01;
  endtask

  task automatic ex_fwd0(input int rs, input bit ready);
    bus.ex_rs[4:0]  = 5'(rs);
    bus.fwd_rd[4:0] = 5'(rs);
    bus.fwd_we      = 2'b01;
    bus.fwd_ready   = {1'b1, ready};
  endtask

  typedef struct {
    logic [9:0] ex_rs;
    logic [9:0] fwd_rd;
    logic [1:0] fwd_we;
    logic [3:0] exp_sel;
  } fvec_t;

  fvec_t tbl [8];

  initial begin
    checks   = 0;
    failures = 0;
    now      = 0;
    reset_model();

    tbl[0] = '{ {5'd4, 5'd3},  {5'd4, 5'd3},  2'b11, 4'b1001 };
    tbl[1] = '{ {5'd3, 5'd3},  {5'd3, 5'd3},  2'b11, 4'b0101 };
    tbl[2] = '{ {5'd3, 5'd3},  {5'd3, 5'd3},  2'b10, 4'b1010 };
    tbl[3] = '{ {5'd3, 5'd3},  {5'd3, 5'd3},  2'b00, 4'b0000 };
    tbl[4] = '{ {5'd0, 5'd0},  {5'd0, 5'd0},  2'b11, 4'b0000 };
    tbl[5] = '{ {5'd9, 5'd7},  {5'd7, 5'd9},  2'b11, 4'b0110 };
    tbl[6] = '{ {5'd9, 5'd7},  {5'd7, 5'd9},  2'b01, 4'b0100 };
    tbl[7] = '{ {5'd31, 5'd12}, {5'd12, 5'd31}, 2'b10, 4'b0010 };

    // Reset state
    rst_n = 0;
    idle();
    tick();
    tick();
    do_issue(3, 4);
    #2;
    chk("reset_stall", bus.stall, 0);
    chk("reset_pending", bus.pending_mask, 0);
    chk("reset_stall_count", bus.stall_count, 0);
    chk("reset_hazard_err", bus.hazard_err, 0);
    tick();
    chk("reset_no_entry", bus.pending_mask, 0);
    idle();
    rst_n = 1;
    tick();

    // Forwarding select table
    for (int k = 0; k < 8; k++) begin
      idle();
      bus.ex_rs  = tbl[k].ex_rs;
      bus.fwd_rd = tbl[k].fwd_rd;
      bus.fwd_we = tbl[k].fwd_we;
      #2;
      chk($sformatf("fwd_table_%0d", k), bus.forward_sel, tbl[k].exp_sel);
      tick();
    end
    idle();
    chk("fwd_table_no_err", bus.hazard_err, 0);

    // ALU chain: latency 1 never stalls
    do_issue(5, 1);
    #2;
    chk("alu_issue_stall", bus.stall, 0);
    tick();
    idle();
    read_src(5);
    #2;
    chk("alu_use_stall", bus.stall, 0);
    chk("alu_pending5", bus.pending_mask[5], 1);
    tick();
    idle();
    ex_fwd0(5, 1);
    #2;
    chk("alu_fwd_sel", bus.forward_sel, 4'b0001);
    chk("alu_drained", bus.pending_mask, 0);
    tick();

    // Load-use: exactly one stall cycle
    idle();
    do_issue(6, 2);
    tick();
    idle();
    read_src(6);
    #2;
    chk("load_stall_c1", bus.stall, 1);
    tick();
    chk("load_stall_c2", bus.stall, 0);
    chk("load_stall_count", bus.stall_count, 1);
    tick();
    idle();
    ex_fwd0(6, 1);
    #2;
    chk("load_fwd_sel", bus.forward_sel, 4'b0001);
    tick();
    chk("load_no_err", bus.hazard_err, 0);

    // Long latency: 4 stall cycles, pending clears after 5
    idle();
    do_issue(7, 5);
    tick();
    idle();
    read_src(7);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("long_stall_%0d", k), bus.stall, (k < 4) ? 1 : 0);
      chk($sformatf("long_pend_%0d", k), bus.pending_mask[7], 1);
      tick();
    end
    idle();
    #1;
    chk("long_pend_clear", bus.pending_mask[7], 0);
    chk("long_stall_count", bus.stall_count, 5);

    // WAW stall and x0 never tracked
    do_issue(8, 5);
    tick();
    idle();
    tick();
    do_issue(8, 1);
    #2;
    chk("waw_stall", bus.stall, 1);
    tick();
    do_issue(0, 5);
    #2;
    chk("x0_no_stall", bus.stall, 0);
    tick();
    idle();
    chk("x0_pending0", bus.pending_mask[0], 0);
    chk("waw_x8_still", bus.pending_mask, 32'h0000_0100);
    chk("waw_stall_count", bus.stall_count, 6);
    repeat (6) tick();

    // Flush kills the just-issued entry and the ID issue
    do_issue(9, 3);
    tick();
    do_issue(10, 4);
    bus.flush = 1;
    #2;
    chk("flush_stall", bus.stall, 0);
    tick();
    idle();
    chk("flush_pending", bus.pending_mask, 0);
    tick();

    // Sticky forwarding error, then async reset mid-operation
    ex_fwd0(3, 0);
    #2;
    chk("err_fwd_sel", bus.forward_sel, 4'b0001);
    tick();
    idle();
    chk("err_set", bus.hazard_err, 1);
    do_issue(7, 8);
    tick();
    idle();
    tick();
    chk("err_holds", bus.hazard_err, 1);
    chk("rst_pre_pending", bus.pending_mask, 32'h0000_0080);
    read_src(7);
    rst_n = 0;
    reset_model();
    #1;
    chk("async_pending", bus.pending_mask, 0);
    chk("async_err", bus.hazard_err, 0);
    chk("async_stall", bus.stall, 0);
    chk("async_stall_count", bus.stall_count, 0);
    tick();
    idle();
    rst_n = 1;
    tick();

    // Randomized traffic vs. reference model
    for (int c = 0; c < 2000; c++) begin
      bus.issue_valid = ($urandom_range(0, 3) != 0);
      bus.issue_rd    = 5'($urandom_range(0, 7));
      bus.issue_we    = ($urandom_range(0, 3) != 0);
      bus.issue_lat   = 4'($urandom_range(0, 10));
      bus.id_rs       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      bus.id_rs_used  = 2'($urandom_range(0, 3));
      bus.ex_rs       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      bus.fwd_rd      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      bus.fwd_we      = 2'($urandom_range(0, 3));
      bus.fwd_ready   = {($urandom_range(0, 31) != 0), ($urandom_range(0, 31) != 0)};
      bus.flush       = ($urandom_range(0, 15) == 0);
      #2;
      chk("rnd_stall", bus.stall, m_stall());
      chk("rnd_fwd_sel", bus.forward_sel, m_fsel_vec());
      chk("rnd_pending", bus.pending_mask, m_pmask());
      chk("rnd_stall_count", bus.stall_count, m_scount);
      chk("rnd_hazard_err", bus.hazard_err, m_err);
      if (c % 300 == 150) begin
        rst_n = 0;
        reset_model();
        #1;
        chk("rnd_async_pending", bus.pending_mask, 0);
        chk("rnd_async_stall", bus.stall, 0);
        tick();
        rst_n = 1;
      end else begin
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
